grant_requester: RTL and testbench



---
 rtl/arb_pkg.sv | 18 +
 rtl/grant_requester_if.sv | 24 ++
 rtl/grant_requester_wdog.sv | 27 ++
 rtl/grant_requester.sv | 117 +++++++++++
 tb/tb_grant_requester.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the priority arbiter and its per-line requester agents.
package arb_pkg;

  localparam int NREQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OWN  = 2'd2,
    ST_GAP  = 2'd3
  } req_state_t;

  // A zero gap still needs one cycle so the arbiter can see req low.
  function automatic int gap_clamp(input int g);
    return (g < 1) ? 1 : g;
  endfunction

endpackage

// File: rtl/grant_requester_if.sv
// Job intake, arbiter r/g pair and status strobes of one requester agent.
interface grant_requester_if #(
  parameter int LEN_W = 4
);
  logic             job_valid;
  logic [LEN_W-1:0] job_len;
  logic             job_ready;
  logic             req;
  logic             gnt;
  logic             beat;
  logic             done;
  logic             timeout;
  logic             lost;

  modport master (
    input  job_valid, job_len, gnt,
    output job_ready, req, beat, done, timeout, lost
  );

  modport slave (
    output job_valid, job_len, gnt,
    input  job_ready, req, beat, done, timeout, lost
  );
endinterface

// File: rtl/grant_requester_wdog.sv
// Saturating wait counter; tc flags the last ungranted cycle before an abort.
module grant_requester_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic en,
  output logic tc
);
  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // TIMEOUT of zero disables the watchdog entirely.
  assign tc = (TIMEOUT != 0) && (cnt_reg == W'(TIMEOUT - 1));
endmodule

// File: rtl/grant_requester.sv
// Requester agent: accepts a job, requests the arbiter, issues job_len+1 beats, then idles for a gap.
module grant_requester
  import arb_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 15
) (
  input logic             clk,
  input logic             resetn,
  grant_requester_if.master bus
);
  localparam int GMAX  = gap_clamp(GAP);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  req_state_t       state_reg;
  logic [LEN_W:0]   rem_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             req_reg;
  logic             done_reg;
  logic             timeout_reg;
  logic             lost_reg;
  logic             accept;
  logic             wd_tc;
  logic             gap_done;
  logic             last_beat;

  assign accept    = (state_reg == ST_IDLE) && bus.job_valid;
  assign gap_done  = (int'(gap_cnt_reg) + 1) >= GMAX;
  assign last_beat = (rem_reg == (LEN_W + 1)'(1));

  grant_requester_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .resetn(resetn),
    .load  (accept),
    .en    ((state_reg == ST_REQ) && !bus.gnt),
    .tc    (wd_tc)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      rem_reg     <= '0;
      gap_cnt_reg <= '0;
      req_reg     <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      lost_reg    <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      lost_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            rem_reg   <= {1'b0, bus.job_len} + 1'b1;
            req_reg   <= 1'b1;
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A grant arriving on the terminal wait cycle beats the watchdog.
          if (bus.gnt) begin
            rem_reg <= rem_reg - 1'b1;
            if (last_beat) begin
              state_reg   <= ST_GAP;
              req_reg     <= 1'b0;
              gap_cnt_reg <= '0;
              done_reg    <= 1'b1;
            end else begin
              state_reg <= ST_OWN;
            end
          end else if (wd_tc) begin
            state_reg   <= ST_GAP;
            req_reg     <= 1'b0;
            gap_cnt_reg <= '0;
            timeout_reg <= 1'b1;
          end
        end
        ST_OWN: begin
          if (bus.gnt) begin
            rem_reg <= rem_reg - 1'b1;
            if (last_beat) begin
              state_reg   <= ST_GAP;
              req_reg     <= 1'b0;
              gap_cnt_reg <= '0;
              done_reg    <= 1'b1;
            end
          end else begin
            state_reg   <= ST_GAP;
            req_reg     <= 1'b0;
            gap_cnt_reg <= '0;
            lost_reg    <= 1'b1;
          end
        end
        ST_GAP: begin
          // Leave only once the arbiter has withdrawn its grant.
          if (gap_done && !bus.gnt) begin
            state_reg <= ST_IDLE;
          end else if (!gap_done) begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.job_ready = resetn && (state_reg == ST_IDLE);
  assign bus.req       = req_reg;
  assign bus.beat      = bus.gnt && req_reg;
  assign bus.done      = done_reg;
  assign bus.timeout   = timeout_reg;
  assign bus.lost      = lost_reg;
endmodule

// File: tb/tb_grant_requester.sv
// Directed bench: vector table for single jobs plus hand sequences for timeout, reset and gap spacing.
module tb_grant_requester;

  logic clk;
  logic resetn;
  int   n_chk;
  int   n_fail;

  grant_requester_if #(.LEN_W(4)) a_if ();
  grant_requester_if #(.LEN_W(4)) b_if ();

  grant_requester #(.LEN_W(4), .GAP(1), .TIMEOUT(15)) u_a (
    .clk   (clk),
    .resetn(resetn),
    .bus   (a_if)
  );

  grant_requester #(.LEN_W(4), .GAP(4), .TIMEOUT(15)) u_b (
    .clk   (clk),
    .resetn(resetn),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       jv;
    logic [3:0] len;
    logic       gnt;
    logic       ready;
    logic       req;
    logic       beat;
    logic       done;
    logic       to;
    logic       lost;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string tag, input logic r, input logic q, input logic b,
                       input logic d, input logic t, input logic l);
    chk({tag, ".job_ready"}, a_if.job_ready, r);
    chk({tag, ".req"},       a_if.req,       q);
    chk({tag, ".beat"},      a_if.beat,      b);
    chk({tag, ".done"},      a_if.done,      d);
    chk({tag, ".timeout"},   a_if.timeout,   t);
    chk({tag, ".lost"},      a_if.lost,      l);
  endtask

  // Advance one cycle, drive DUT a inputs for it, then settle before sampling.
  task automatic step(input logic jv, input logic [3:0] len, input logic g);
    @(posedge clk);
    #1;
    a_if.job_valid = jv;
    a_if.job_len   = len;
    a_if.gnt       = g;
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    resetn = 1'b0;
    a_if.job_valid = 1'b0; a_if.job_len = '0; a_if.gnt = 1'b1;
    b_if.job_valid = 1'b0; b_if.job_len = '0; b_if.gnt = 1'b0;

    // job_len=2, grant 1 cycle after req, held 1 cycle past req fall
    vq.push_back('{1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    // job_len=0, job_valid while busy must be ignored
    vq.push_back('{1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    // job_len=5, grant lost after the second beat
    vq.push_back('{1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    vq.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    // reset state, with gnt forced high to prove beat stays low
    #3;
    chk_a("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    a_if.gnt = 1'b0;
    resetn = 1'b1;
    #1;
    chk("reset_release.job_ready", a_if.job_ready, 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].jv, vq[i].len, vq[i].gnt);
      chk_a($sformatf("vec%0d", i), vq[i].ready, vq[i].req, vq[i].beat,
            vq[i].done, vq[i].to, vq[i].lost);
      $display("vec %0d: jv=%b len=%0d gnt=%b -> ready=%b req=%b beat=%b done=%b to=%b lost=%b",
               i, vq[i].jv, vq[i].len, vq[i].gnt, a_if.job_ready, a_if.req, a_if.beat,
               a_if.done, a_if.timeout, a_if.lost);
    end

    // maximum job length: 16 beats
    begin
      int beats;
      beats = 0;
      step(1'b1, 4'd15, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      chk("max.req", a_if.req, 1'b1);
      for (int k = 0; k < 16; k++) begin
        step(1'b0, 4'd0, 1'b1);
        if (a_if.beat === 1'b1) beats++;
        chk($sformatf("max.done%0d", k), a_if.done, 1'b0);
      end
      step(1'b0, 4'd0, 1'b1);
      chk_int("max.beats", beats, 16);
      chk_a("max.end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      chk("max.idle", a_if.job_ready, 1'b1);
      $display("max-length job: %0d beats", beats);
    end

    // watchdog: 15 ungranted req cycles, then a timeout pulse
    step(1'b1, 4'd3, 1'b0);
    chk("to.accept", a_if.job_ready, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      step(1'b0, 4'd0, 1'b0);
      chk($sformatf("to.req%0d", k), a_if.req, 1'b1);
      chk($sformatf("to.timeout%0d", k), a_if.timeout, 1'b0);
    end
    step(1'b0, 4'd0, 1'b0);
    chk_a("to.pulse", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk_a("to.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("timeout sequence: idle again, ready=%b", a_if.job_ready);

    // grant arriving on the 15th ungranted cycle wins over the watchdog
    step(1'b1, 4'd0, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 4'd0, 1'b0);
      chk($sformatf("race.req%0d", k), a_if.req, 1'b1);
    end
    step(1'b0, 4'd0, 1'b1);
    chk_a("race.beat", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    chk_a("race.done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk_a("race.gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk("race.idle", a_if.job_ready, 1'b1);
    $display("grant/timeout race: beat taken, no timeout");

    // reset in OWN with 3 beats left
    step(1'b1, 4'd4, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    chk_a("rst.own", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    #1;
    chk_a("rst.asserted", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    a_if.gnt = 1'b0;
    resetn = 1'b1;
    #1;
    chk_a("rst.release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'd0, 1'b0);
      chk_a($sformatf("rst.after%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    $display("reset mid-job: ready=%b req=%b", a_if.job_ready, a_if.req);

    // GAP=4 agent, job_valid held high, arbiter grants one cycle after req
    begin
      int   accepts, beats, dones, low_run, gap_seen;
      logic prev_req, seen_high;
      accepts = 0; beats = 0; dones = 0; low_run = 0; gap_seen = -1;
      prev_req = 1'b0; seen_high = 1'b0;
      for (int c = 0; c < 16; c++) begin
        @(posedge clk);
        #1;
        b_if.job_valid = 1'b1;
        b_if.job_len   = 4'd1;
        b_if.gnt       = prev_req;
        #1;
        if (b_if.job_ready && b_if.job_valid) accepts++;
        if (b_if.beat) beats++;
        if (b_if.done) dones++;
        if (b_if.req) begin
          if (seen_high && low_run > 0 && gap_seen < 0) gap_seen = low_run;
          seen_high = 1'b1;
          low_run = 0;
        end else if (seen_high) begin
          low_run++;
        end
        prev_req = b_if.req;
      end
      b_if.job_valid = 1'b0;
      chk_int("gap4.accepts", accepts, 2);
      chk_int("gap4.beats", beats, 4);
      chk_int("gap4.dones", dones, 2);
      chk_int("gap4.req_low_cycles", gap_seen, 5);
      $display("gap=4 back-to-back: accepts=%0d beats=%0d dones=%0d req-low=%0d",
               accepts, beats, dones, gap_seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
